// File: rtl/trace_config_sequencer_pkg.sv
// Shared state, default and firmware encodings for the trace configuration sequencer.
package trace_config_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_STREAM = 3'd2,
    ST_GAP    = 3'd3,
    ST_RESUME = 3'd4
  } seq_state_e;

  localparam logic [7:0] DEFAULT_IDLE_CONFIG_ID = 8'hFF;

  // Firmware length-field encoding understood by the instrumentation blocks.
  typedef enum logic [1:0] {
    FW_LEN_N   = 2'd0,
    FW_LEN_M   = 2'd1,
    FW_LEN_ONE = 2'd2
  } fw_len_e;

  // Firmware condition bit positions.
  localparam int COND_LAST     = 0;
  localparam int COND_NOTLAST  = 1;
  localparam int COND_FIRST    = 2;
  localparam int COND_NOTFIRST = 3;

  typedef logic [3:0] fw_cond_t;

endpackage

// File: rtl/trace_config_sequencer_buffer.sv
// cfg_byte_buffer: staging RAM for configuration bytes.
// One write port; the read address is registered and read data is combinational from it.
module cfg_byte_buffer
  import trace_config_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_addr_q;

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_addr_q <= '0;
    else       rd_addr_q <= rd_addr;
  end

  assign rd_data = mem[rd_addr_q];

endmodule

// File: rtl/trace_config_sequencer.sv
// Quiesces tracing, streams staged configuration bytes to one instrumentation block, then resumes.
// Optional cfg_checksum output is built when TRACE_CFG_CHECKSUM_EN is defined.
//
// state  | meaning
// IDLE   | tracing follows trace_enable, buffer writable, accepts start
// DRAIN  | tracing held low for DRAIN_CYCLES so in-flight trace data settles
// STREAM | one staged byte per cycle with configId = latched target
// GAP    | one idle configId cycle so the receiver's byte counter clears
// RESUME | done pulse, tracing reloaded from trace_enable
module trace_config_sequencer
  import trace_config_sequencer_pkg::*;
#(
  parameter int         MAX_BYTES      = 16,
  parameter int         DRAIN_CYCLES   = 4,
  parameter logic [7:0] IDLE_CONFIG_ID = DEFAULT_IDLE_CONFIG_ID,
  localparam int        AW             = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1,
  localparam int        IW             = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          trace_enable,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          start,
  input  logic [7:0]    target_id,
  input  logic [IW-1:0] byte_count,
  output logic          tracing,
  output logic [7:0]    configId,
  output logic [7:0]    configData,
  output logic          busy,
  output logic          done,
  output logic          err
`ifdef TRACE_CFG_CHECKSUM_EN
  ,
  output logic [7:0]    cfg_checksum
`endif
);

  localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  seq_state_e    state_q, state_d;
  logic [7:0]    target_q;
  logic [IW-1:0] count_q;
  logic [IW-1:0] idx_q, idx_nxt;
  logic [DW-1:0] drain_cnt_q;
  logic          count_valid, start_ok, start_bad;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;

  assign count_valid = (byte_count != '0) && (byte_count <= IW'(MAX_BYTES));
  assign idx_nxt     = idx_q + IW'(1);

  cfg_byte_buffer #(
    .DEPTH (MAX_BYTES),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en && (state_q == ST_IDLE)),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tracing     <= 1'b0;
      err         <= 1'b0;
      target_q    <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      err     <= start_bad;
      if (state_q == ST_RESUME || (state_q == ST_IDLE && !start_ok)) tracing <= trace_enable;
      else                                                          tracing <= 1'b0;
      if (start_ok) begin
        target_q    <= target_id;
        count_q     <= byte_count;
        idx_q       <= '0;
        drain_cnt_q <= DRAIN_LAST;
      end else if (state_q == ST_DRAIN && drain_cnt_q != '0) begin
        drain_cnt_q <= drain_cnt_q - DW'(1);
      end else if (state_q == ST_STREAM) begin
        idx_q <= idx_nxt;
      end
    end
  end

  // Read address runs one ahead of idx_q because the buffer registers it.
  always_comb begin
    state_d    = state_q;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    configId   = IDLE_CONFIG_ID;
    configData = 8'h00;
    rd_addr    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count_valid) begin
            start_ok = 1'b1;
            state_d  = ST_DRAIN;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt_q == '0) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        busy       = 1'b1;
        configId   = target_q;
        configData = rd_data;
        rd_addr    = idx_nxt[AW-1:0];
        if (idx_q == count_q - IW'(1)) state_d = ST_GAP;
      end
      ST_GAP: begin
        busy    = 1'b1;
        state_d = ST_RESUME;
      end
      ST_RESUME: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef TRACE_CFG_CHECKSUM_EN
  logic [7:0] checksum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    checksum_q <= 8'h00;
    else if (start_ok)            checksum_q <= 8'h00;
    else if (state_q == ST_STREAM) checksum_q <= checksum_q ^ rd_data;
  end

  assign cfg_checksum = checksum_q;
`endif

endmodule

// File: tb/tb_trace_config_sequencer.sv
// Directed bench for trace_config_sequencer: schedule-based reference model plus literal checks.
// Checksum checks are included when TRACE_CFG_CHECKSUM_EN is defined.
module tb_trace_config_sequencer;

  localparam int MAXB  = 16;
  localparam int DRAIN = 4;
  localparam int IW    = 5;

  logic          clk;
  logic          reset = 1'b1;
  logic          trace_enable, wr_en, start;
  logic [3:0]    wr_addr;
  logic [7:0]    wr_data, target_id;
  logic [IW-1:0] byte_count;
  logic          tracing, busy, done, err;
  logic [7:0]    configId, configData;
`ifdef TRACE_CFG_CHECKSUM_EN
  logic [7:0]    cfg_checksum;
`endif

  trace_config_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .trace_enable (trace_enable),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .target_id    (target_id),
    .byte_count   (byte_count),
    .tracing      (tracing),
    .configId     (configId),
    .configData   (configData),
    .busy         (busy),
    .done         (done),
    .err          (err)
`ifdef TRACE_CFG_CHECKSUM_EN
    ,
    .cfg_checksum (cfg_checksum)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: an accepted start expands into a per-cycle schedule of expected outputs.
  typedef struct packed {
    logic       tr;
    logic [7:0] id;
    logic [7:0] dat;
    logic       bsy;
    logic       dn;
  } exp_t;

  exp_t       sched[$];
  exp_t       ent;
  bit         m_idle;
  int         bcv;
  logic [7:0] mbuf [0:MAXB-1];
  logic [7:0] m_ck;
  logic       e_tracing, e_busy, e_done, e_err;
  logic [7:0] e_id, e_data;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sched.delete();
      m_idle = 1'b1; m_ck = 8'h00;
      e_tracing = 1'b0; e_id = 8'hFF; e_data = 8'h00;
      e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
    end else if (sched.size() > 0) begin
      ent = sched.pop_front();
      e_tracing = ent.tr; e_id = ent.id; e_data = ent.dat; e_busy = ent.bsy; e_done = ent.dn;
      e_err = 1'b0;
    end else if (!m_idle) begin
      m_idle = 1'b1;
      e_tracing = trace_enable; e_id = 8'hFF; e_data = 8'h00;
      e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
    end else begin
      if (wr_en) mbuf[wr_addr] = wr_data;
      bcv = int'(byte_count);
      e_err = 1'b0;
      if (start && bcv >= 1 && bcv <= MAXB) begin
        m_idle = 1'b0;
        m_ck = 8'h00;
        ent = '{tr: 1'b0, id: 8'hFF, dat: 8'h00, bsy: 1'b1, dn: 1'b0};
        for (int i = 0; i < DRAIN; i++) sched.push_back(ent);
        for (int k = 0; k < bcv; k++) begin
          sched.push_back('{tr: 1'b0, id: target_id, dat: mbuf[k], bsy: 1'b1, dn: 1'b0});
          m_ck = m_ck ^ mbuf[k];
        end
        sched.push_back(ent);
        sched.push_back('{tr: 1'b0, id: 8'hFF, dat: 8'h00, bsy: 1'b0, dn: 1'b1});
        ent = sched.pop_front();
        e_tracing = ent.tr; e_id = ent.id; e_data = ent.dat; e_busy = ent.bsy; e_done = ent.dn;
      end else begin
        e_err = start;
        e_tracing = trace_enable; e_id = 8'hFF; e_data = 8'h00;
        e_busy = 1'b0; e_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk1("tracing", tracing, e_tracing);
    chk8("configId", configId, e_id);
    chk8("configData", configData, e_data);
    chk1("busy", busy, e_busy);
    chk1("done", done, e_done);
    chk1("err", err, e_err);
`ifdef TRACE_CFG_CHECKSUM_EN
    if (e_done) chk8("cfg_checksum_model", cfg_checksum, m_ck);
`endif
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  logic [7:0] got [0:MAXB-1];
  logic       tr_k1;
  int         done_k;

  // Issues a start and follows it to done; inj drives a start plus a write in the 2nd stream cycle.
  task automatic run_seq(input logic [7:0] tid, input int bc, input bit inj);
    int s0, k;
    bit seen;
    seen = 1'b0; done_k = -1; tr_k1 = 1'bx;
    target_id = tid; byte_count = bc[IW-1:0]; start = 1'b1; s0 = cyc;
    step();
    start = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      k = cyc - s0;
      if (k == 1) tr_k1 = tracing;
      if (k >= DRAIN + 1 && k < DRAIN + 1 + bc) got[k-DRAIN-1] = configData;
      if (done) begin
        seen = 1'b1; done_k = k;
      end else begin
        if (inj && k == DRAIN + 2) begin
          start = 1'b1; target_id = 8'h55; byte_count = 5'd3;
          wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h77;
        end
        step();
        start = 1'b0; wr_en = 1'b0;
      end
    end
    chk1("done_seen", seen, 1'b1);
  endtask

  logic [7:0] lit29 [0:7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'h01, 8'h00};
  int  s0m;
  bit  seen_done;

  initial begin
    trace_enable = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; target_id = '0; byte_count = '0;
    step(); step();
    chk8("rst_configId", configId, 8'hFF);
    chk8("rst_configData", configData, 8'h00);
    chk1("rst_tracing", tracing, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    reset = 1'b0;
    step();
    trace_enable = 1'b1;
    step(); step();
    chk1("idle_tracing_follows", tracing, 1'b1);

    for (int i = 0; i < 8; i++) write_byte(4'(i), lit29[i]);
    run_seq(8'd3, 8, 1'b0);
    chk1("trace_low_after_start", tr_k1, 1'b0);
    chki("done_latency_bc8", done_k, 14);
    for (int i = 0; i < 8; i++) chk8("stream_order", got[i], lit29[i]);
    step();
    chk1("tracing_after_resume_te1", tracing, 1'b1);

    start = 1'b1; byte_count = 5'd0;
    step();
    start = 1'b0;
    chk1("err_bc0", err, 1'b1);
    chk1("busy_bc0", busy, 1'b0);
    chk1("tracing_bc0", tracing, 1'b1);
    step();
    chk1("err_one_cycle", err, 1'b0);
    start = 1'b1; byte_count = 5'd17;
    step();
    start = 1'b0;
    chk1("err_bc17", err, 1'b1);
    chk1("busy_bc17", busy, 1'b0);

    trace_enable = 1'b0;
    step(); step();
    run_seq(8'h0A, 6, 1'b1);
    chki("done_latency_bc6", done_k, 12);
    for (int i = 0; i < 6; i++) chk8("stream_frozen", got[i], lit29[i]);
    step();
    chk1("tracing_after_resume_te0", tracing, 1'b0);
    run_seq(8'h0B, 3, 1'b0);
    chk8("buf2_unchanged", got[2], 8'h00);
    step();

    for (int i = 0; i < MAXB; i++) write_byte(4'(i), 8'(i * 7 + 1));
    run_seq(8'd1, 16, 1'b0);
    chki("done_latency_bc16", done_k, 22);
    chk8("last_byte_bc16", got[15], 8'h6A);
    step();
    run_seq(8'd2, 1, 1'b0);
    chki("done_latency_bc1", done_k, 7);
    chk8("only_byte_bc1", got[0], 8'h01);
    step();

    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h5C;
    run_seq(8'd4, 2, 1'b0);
    chk8("write_with_start", got[0], 8'h5C);
    chki("done_latency_bc2", done_k, 8);
    step();

    trace_enable = 1'b1;
    target_id = 8'd9; byte_count = 5'd8; start = 1'b1; s0m = cyc;
    step();
    start = 1'b0;
    while (cyc - s0m < DRAIN + 3) step();
    reset = 1'b1;
    step();
    chk8("abort_configId", configId, 8'hFF);
    chk1("abort_tracing", tracing, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk8("abort_configData", configData, 8'h00);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (25) begin
      step();
      if (done) seen_done = 1'b1;
    end
    chk1("no_done_after_abort", seen_done, 1'b0);

`ifdef TRACE_CFG_CHECKSUM_EN
    write_byte(4'd0, 8'hA5);
    write_byte(4'd1, 8'h0F);
    run_seq(8'd5, 2, 1'b0);
    chk8("cfg_checksum_a5_0f", cfg_checksum, 8'hAA);
    step();
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/trace_config_sequencer.md
TRACE_CONFIG_SEQUENCER -- requirements
Module: trace_config_sequencer

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 16: staging-buffer depth in bytes.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4: number of cycles between tracing deassertion and the first configuration byte.
REQ-003 SHALL have parameter IDLE_CONFIG_ID, default 8'hFF: the configId value that no instrumentation block owns.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk (in, 1, rising-edge clock) and reset (in, 1, asynchronous active-high reset).
REQ-005 SHALL have trace_enable (in, 1): host requests tracing when idle.
REQ-006 SHALL have wr_en, wr_addr and wr_data (in, 1 / clog2(MAX_BYTES) / 8): staging-buffer write port.
REQ-007 SHALL have start, target_id and byte_count (in, 1 / 8 / clog2(MAX_BYTES)+1): reconfiguration request.
REQ-008 SHALL have tracing, configId and configData (out, 1 / 8 / 8): drive the instrumentation chain's tracing/configId/configData inputs.
REQ-009 SHALL have busy, done and err (out, 1 each): busy is a level; done and err are one-cycle pulses.

Function
REQ-010 SHALL implement FSM states IDLE, DRAIN, STREAM, GAP and RESUME.
REQ-011 IDLE: tracing SHALL be registered from trace_enable (1-cycle lag); configId SHALL be IDLE_CONFIG_ID; busy SHALL be 0.
REQ-012 A start in IDLE with 1 <= byte_count <= MAX_BYTES SHALL latch target_id and byte_count, clear tracing, set busy, and enter DRAIN on the next edge.
REQ-013 A start in IDLE with byte_count 0 or byte_count > MAX_BYTES SHALL pulse err for 1 cycle and leave the state unchanged.
REQ-014 DRAIN SHALL last exactly DRAIN_CYCLES cycles, with tracing=0 and configId=IDLE_CONFIG_ID.
REQ-015 STREAM SHALL last byte_count cycles; in cycle k (0-based), configId SHALL be target_id and configData SHALL be buf[k]; there SHALL be no stalls.
REQ-016 GAP SHALL last 1 cycle with configId=IDLE_CONFIG_ID, so the receiver's byte counter clears.
REQ-017 RESUME SHALL last 1 cycle: done pulses, busy falls, tracing is reloaded from trace_enable, and the FSM returns to IDLE.
REQ-018 Total latency from start edge to done SHALL be DRAIN_CYCLES + byte_count + 2 cycles.
REQ-019 start while busy SHALL be ignored, with no err pulse; wr_en while busy SHALL be ignored, so the buffer is frozen during a sequence.
REQ-020 wr_en in IDLE SHALL write buf[wr_addr] on the edge; a wr_en coinciding with an accepted start SHALL complete before streaming begins.
REQ-021 configData SHALL be 0 in every state other than STREAM.
REQ-022 The byte index SHALL be clog2(MAX_BYTES)+1 bits wide and SHALL never wrap; STREAM ends when index == byte_count-1.

Reset
REQ-023 Reset SHALL force IDLE, tracing=0, configId=IDLE_CONFIG_ID, configData=0, busy=0, done=0 and err=0; buffer contents are not reset.
REQ-024 Reset asserted mid-DRAIN or mid-STREAM SHALL abort immediately, and no done SHALL follow.

Configuration
REQ-025 With TRACE_CFG_CHECKSUM_EN defined, the block SHALL add output cfg_checksum (8 bits): the XOR of all bytes streamed in the last sequence, cleared on accepted start, valid when done pulses, and reset to 0.
REQ-026 Without TRACE_CFG_CHECKSUM_EN, the port and its logic SHALL be absent.

Structure
REQ-027 The shared package SHALL hold the FSM state enum, the IDLE_CONFIG_ID default, and the firmware/condition encodings: length N=0, M=1, 1=2; condition bits last, notlast, first, notfirst.
REQ-028 The staging buffer SHALL be a separate sub-module, cfg_byte_buffer (1 write port, 1 read port, registered read address, combinational read data).

Verification
REQ-029 Write buf[0..7] = {8'h00,8'h00,8'h00,8'h00,8'h02,8'h02,8'h01,8'h00}; start with target_id=3, byte_count=8 -> tracing low 1 cycle after start, 4 DRAIN cycles, 8 STREAM cycles with configId=3 and data in order, 1 GAP cycle with configId=8'hFF, done at cycle 14.
REQ-030 start with byte_count=0, then start with byte_count=17 -> err pulses each time, busy stays 0, tracing unchanged.
REQ-031 A second start and a wr_en to addr 2 issued during STREAM -> both ignored; streamed data and buf[2] unchanged.
REQ-032 Reset asserted in the 3rd STREAM cycle -> next cycle has configId=8'hFF, tracing=0, busy=0, and done never pulses.
REQ-033 A sequence with trace_enable=1 before and after -> tracing is 1 in the cycle after RESUME; with trace_enable=0 -> tracing stays 0.
REQ-034 TRACE_CFG_CHECKSUM_EN built, bytes {8'hA5, 8'h0F} -> cfg_checksum = 8'hAA when done pulses.
